// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_FILE_ADDRESS_LEN = 4;
    localparam int unsigned WAIT_CNT_W           = 8;
    localparam int unsigned PERF_CNT_W           = 32;

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } ctrl_state_e;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard comparator between the ID-stage sources and the EX/MEM destinations.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_FILE_ADDRESS_LEN-1:0] id_src1,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] id_src2,
    input  logic                            id_two_src,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] ex_dst,
    input  logic                            ex_wb_en,
    input  logic                            ex_mem_read,
    input  logic [REG_FILE_ADDRESS_LEN-1:0] mem_dst,
    input  logic                            mem_wb_en,
    output logic                            hazard
);

    logic ex_match;
    logic mem_match;

    assign ex_match  = (ex_dst == id_src1) | (id_two_src & (ex_dst == id_src2));
    assign mem_match = (mem_dst == id_src1) | (id_two_src & (mem_dst == id_src2));

    generate
        if (FWD_EN) begin : g_fwd
            // Forwarding covers everything except a load result still in EX.
            assign hazard = ex_mem_read & ex_wb_en & ex_match;
        end else begin : g_nofwd
            assign hazard = (ex_wb_en & ex_match) | (mem_wb_en & mem_match);
        end
    endgenerate

    logic unused_mem;
    assign unused_mem = ^{mem_match, mem_wb_en, ex_mem_read};

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RAW bubbles, branch flushes, memory wait.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit          FWD_EN      = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic [3:0]  ex_dst,
    input  logic        ex_wb_en,
    input  logic        ex_mem_read,
    input  logic [3:0]  mem_dst,
    input  logic        mem_wb_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        freeze_pc,
    output logic        freeze_ifid,
    output logic        flush_ifid,
    output logic        freeze_idex,
    output logic        flush_idex,
    output logic        freeze_back,
`ifdef PIPELINE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_wait_cnt,
`endif
    output logic        mem_err
);

    localparam logic [WAIT_CNT_W-1:0] TimeoutVal = WAIT_CNT_W'(MEM_TIMEOUT);

    ctrl_state_e           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  br_pend_q, br_pend_d;
    logic                  mem_err_q, mem_err_d;

    logic hazard;
    logic frz_front, frz_back, fl_ifid, fl_idex, bubble;
    logic stall_ev, flush_ev;

    hazard_detect #(
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_two_src  (id_two_src),
        .ex_dst      (ex_dst),
        .ex_wb_en    (ex_wb_en),
        .ex_mem_read (ex_mem_read),
        .mem_dst     (mem_dst),
        .mem_wb_en   (mem_wb_en),
        .hazard      (hazard)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        br_pend_d  = br_pend_q;
        mem_err_d  = mem_err_q;
        frz_front  = 1'b0;
        frz_back   = 1'b0;
        fl_ifid    = 1'b0;
        fl_idex    = 1'b0;
        bubble     = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        unique case (state_q)
            StRun: begin
                if (mem_req && !mem_ready) begin
                    frz_front  = 1'b1;
                    frz_back   = 1'b1;
                    state_d    = StMemWait;
                    wait_cnt_d = WAIT_CNT_W'(1);
                    if (branch_taken) br_pend_d = 1'b1;
                end else if (branch_taken || br_pend_q) begin
                    // Wrong-path instructions are discarded, so any hazard is moot.
                    fl_ifid   = 1'b1;
                    fl_idex   = 1'b1;
                    br_pend_d = 1'b0;
                    flush_ev  = 1'b1;
                end else if (hazard) begin
                    bubble   = 1'b1;
                    stall_ev = 1'b1;
                end
            end
            StMemWait: begin
                frz_front  = 1'b1;
                frz_back   = 1'b1;
                wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                if (branch_taken) br_pend_d = 1'b1;
                if (mem_ready) begin
                    state_d = StRun;
                end else if (wait_cnt_q == TimeoutVal) begin
                    mem_err_d = 1'b1;
                    state_d   = StRun;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            br_pend_q  <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_pend_q  <= br_pend_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign freeze_pc   = ~rst & (frz_front | bubble);
    assign freeze_ifid = ~rst & (frz_front | bubble);
    assign flush_ifid  = ~rst & fl_ifid;
    assign freeze_idex = ~rst & frz_front;
    assign flush_idex  = ~rst & (fl_idex | bubble);
    assign freeze_back = ~rst & frz_back;
    assign mem_err     = mem_err_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, flush_cnt_q, wait_cnt_perf_q;

    // Wait cycles include the RUN cycle that first detects the stalled access.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
            wait_cnt_perf_q <= '0;
        end else begin
            if (stall_ev) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush_ev) flush_cnt_q <= sat_inc(flush_cnt_q);
            if (frz_back) wait_cnt_perf_q <= sat_inc(wait_cnt_perf_q);
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
    assign perf_wait_cnt  = wait_cnt_perf_q;
`endif

endmodule
